// File: rtl/if_id_fetch_queue.sv
// IF/ID boundary FIFO: buffers fetched instruction packets (instr, PC+4, prediction bit)
// between fetch and decode with valid/ready handshakes and a single-cycle flush.
module if_id_fetch_queue #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [PC_W-1:0]   in_pc_plus4,
  input  logic              in_pred_taken,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [PC_W-1:0]   out_pc_plus4,
  output logic              out_pred_taken,
  output logic [CNT_W-1:0]  count,
  output logic              almost_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = DATA_W + PC_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  logic [ENT_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [ENT_W-1:0] head_reg, head_next;
  logic [ENT_W-1:0] in_pkt;
  logic             push, pop;
  logic             ready_int, valid_int;

  assign in_pkt     = {in_instr, in_pc_plus4, in_pred_taken};
  assign ready_int  = (count_reg < FULL_CNT);
  assign valid_int  = (count_reg != '0);
  assign push       = in_valid & ready_int & ~flush_en;
  assign pop        = valid_int & out_ready & ~flush_en;
  assign rd_ptr_inc = rd_ptr_reg + PTR_W'(1);

  // Storage is never reset: the head register masks stale contents while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_pkt;
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush_en) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_inc;
      if (push && !pop)      count_next = count_reg + ONE_CNT;
      else if (pop && !push) count_next = count_reg - ONE_CNT;
    end
  end

  // Head register holds the packet decode sees; it only moves on pop,
  // push-into-empty or flush, so no in_* to out_* combinational path exists.
  always_comb begin
    head_next = head_reg;
    if (flush_en) begin
      head_next = '0;
    end else if (pop) begin
      if (count_reg > ONE_CNT) head_next = mem[rd_ptr_inc];
      else if (push)           head_next = in_pkt;
      else                     head_next = '0;
    end else if (push && !valid_int) begin
      head_next = in_pkt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      head_reg   <= head_next;
    end
  end

  assign in_ready       = ready_int;
  assign out_valid      = valid_int;
  assign count          = count_reg;
  assign almost_full    = (count_reg >= AFULL_CNT);
  assign out_instr      = valid_int ? head_reg[ENT_W-1 -: DATA_W] : '0;
  assign out_pc_plus4   = valid_int ? head_reg[PC_W:1] : '0;
  assign out_pred_taken = valid_int & head_reg[0];

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed plus randomized bench for if_id_fetch_queue against a queue-based reference model.
module tb_if_id_fetch_queue;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [PC_W-1:0]   pc;
    logic              pt;
  } pkt_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush_en;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [PC_W-1:0]   in_pc_plus4;
  logic              in_pred_taken;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [PC_W-1:0]   out_pc_plus4;
  logic              out_pred_taken;
  logic [CNT_W-1:0]  count;
  logic              almost_full;

  int   n_assert = 0;
  int   n_fail   = 0;
  pkt_t q[$];

  if_id_fetch_queue #(.DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_en(flush_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc_plus4(in_pc_plus4), .in_pred_taken(in_pred_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc_plus4(out_pc_plus4), .out_pred_taken(out_pred_taken),
    .count(count), .almost_full(almost_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the queue.
  task automatic check_all(input string tag);
    pkt_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk({tag, ".count"},     64'(count),          64'(q.size()));
    chk({tag, ".out_valid"}, 64'(out_valid),      64'(q.size() != 0));
    chk({tag, ".in_ready"},  64'(in_ready),       64'(q.size() < DEPTH));
    chk({tag, ".afull"},     64'(almost_full),    64'(q.size() >= DEPTH - 1));
    chk({tag, ".instr"},     64'(out_instr),      64'(h.instr));
    chk({tag, ".pc4"},       64'(out_pc_plus4),   64'(h.pc));
    chk({tag, ".pt"},        64'(out_pred_taken), 64'(h.pt));
    $display("%0t %s: in_v=%0b in_r=%0b out_v=%0b out_r=%0b fl=%0b cnt=%0d head=%h",
             $time, tag, in_valid, in_ready, out_valid, out_ready, flush_en, count, out_instr);
  endtask

  task automatic step(input string tag);
    bit push, pop;
    @(posedge clk);
    push = in_valid && (q.size() < DEPTH) && !flush_en;
    pop  = (q.size() != 0) && out_ready && !flush_en;
    if (flush_en) q.delete();
    else begin
      if (pop)  q.delete(0);
      if (push) q.push_back('{in_instr, in_pc_plus4, in_pred_taken});
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic pt);
    in_valid = v; in_instr = ins; in_pc_plus4 = pc; in_pred_taken = pt;
  endtask

  initial begin
    rst_n = 1'b0; flush_en = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'hDEADBEEF, 32'h100, 1'b1);

    // Reset held with in_valid=1: nothing may enter.
    repeat (3) begin
      @(posedge clk); #1;
      check_all("reset_hold");
    end
    #2 rst_n = 1'b1;
    in_valid = 1'b0;
    #1 check_all("after_reset");

    // Two pushes under stall.
    @(negedge clk);
    drive(1'b1, 32'h8C010004, 32'h04, 1'b0); step("push_a");
    chk("push_a.count1", 64'(count), 64'd1);
    drive(1'b1, 32'h10220003, 32'h08, 1'b1); step("push_b");
    chk("push_b.count2", 64'(count), 64'd2);
    chk("push_b.afull0", 64'(almost_full), 64'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("stall");
      chk("stall.head", 64'(out_instr), 64'h8C010004);
    end

    // Fill to full, then offer a fifth packet.
    drive(1'b1, 32'h00430820, 32'h0C, 1'b0); step("push_c");
    chk("push_c.afull1", 64'(almost_full), 64'd1);
    drive(1'b1, 32'hAC010008, 32'h10, 1'b1); step("push_d");
    chk("full.in_ready", 64'(in_ready), 64'd0);
    drive(1'b1, 32'h08000010, 32'h14, 1'b0); step("fifth_blocked");
    chk("fifth.count4", 64'(count), 64'd4);
    out_ready = 1'b1; step("pop_while_full");
    chk("pop_full.count3", 64'(count), 64'd3);
    chk("pop_full.head", 64'(out_instr), 64'h10220003);
    out_ready = 1'b0; step("fifth_accepted");
    chk("fifth_acc.count4", 64'(count), 64'd4);

    // Drain in order.
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step("drain");
    chk("drain.empty", 64'(out_valid), 64'd0);

    // Streaming: one packet per cycle, count stays at 1.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 32'h10000000 + 32'(i), 32'(4 * (i + 1)), 1'(i));
      step("stream");
      chk("stream.count1", 64'(count), 64'd1);
      chk("stream.head", 64'(out_instr), 64'(32'h10000000 + 32'(i)));
    end

    // Build count=3 then flush with push and pop both requested.
    out_ready = 1'b0;
    drive(1'b1, 32'h20000001, 32'h200, 1'b0); step("pre_flush");
    drive(1'b1, 32'h20000002, 32'h204, 1'b1); step("pre_flush");
    chk("pre_flush.count3", 64'(count), 64'd3);
    flush_en = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h20000003, 32'h208, 1'b1); step("flush");
    chk("flush.count0", 64'(count), 64'd0);
    chk("flush.out_valid", 64'(out_valid), 64'd0);
    chk("flush.instr0", 64'(out_instr), 64'd0);
    flush_en = 1'b0;

    // Push into empty with out_ready=1: no pop, visible next cycle.
    drive(1'b1, 32'h3C01ABCD, 32'h300, 1'b1); step("push_empty");
    chk("push_empty.count1", 64'(count), 64'd1);
    chk("push_empty.head", 64'(out_instr), 64'h3C01ABCD);

    // Randomized traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush_en  = ($urandom_range(0, 15) == 0);
      step("rand");
      if (i == 200) begin
        rst_n = 1'b0;
        #2;
        q.delete();
        check_all("async_reset");
        #2 rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id_fetch_queue.md
# if_id_fetch_queue

Parametrised IF/ID boundary buffer that replaces the single-entry IF/ID register with a DEPTH-entry FIFO of fetched instruction packets. Each packet holds the instruction word, PC+4 and the branch-prediction bit. The queue decouples the fetch stage (producer) from decode (consumer) with valid/ready handshakes on both sides. It also provides a one-cycle whole-queue flush for branch mispredictions and jumps.

## Interface
Parameters:
- DATA_W, 32, instruction word width
- PC_W, 32, PC+4 width
- DEPTH, 4, number of entries; power of two, ≥ 2
- CNT_W, $clog2(DEPTH)+1, width of occupancy count (derived; do not override)

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- flush_en  in  1  synchronous flush of all entries
- in_valid  in  1  fetch presents a packet
- in_ready  out  1  queue can accept a packet this cycle
- in_instr  in  DATA_W  fetched instruction
- in_pc_plus4  in  PC_W  PC+4 of fetched instruction
- in_pred_taken  in  1  predictor decision for this instruction
- out_valid  out  1  head packet valid for decode
- out_ready  in  1  decode consumes head this cycle
- out_instr  out  DATA_W  head instruction; 0 when empty
- out_pc_plus4  out  PC_W  head PC+4; 0 when empty
- out_pred_taken  out  1  head prediction bit; 0 when empty
- count  out  CNT_W  occupied entries, 0..DEPTH
- almost_full  out  1  count ≥ DEPTH-1, used to throttle fetch

## Operation
- Storage: DEPTH × (DATA_W+PC_W+1) array. Write pointer and read pointer are each $clog2(DEPTH) bits, plus a registered count.
- push = in_valid & in_ready. in_ready = (count < DEPTH). in_ready is a function of state only and does not depend on out_ready.
- pop = out_valid & out_ready. out_valid = (count != 0).
- On push: the entry at the write pointer is written and the write pointer increments. On pop: the read pointer increments. Pointers wrap naturally modulo DEPTH.
- count update: +1 on push only, −1 on pop only, unchanged on push and pop together or on neither.
- When full, in_ready=0. A pop in that cycle frees an entry, but the freed slot is visible to fetch only from the next cycle.
- When empty, out_valid=0 and all out_* data are forced to 0, so decode sees a NOP bubble (sll $0,$0,0).
- flush_en has priority over push and pop. In the flush cycle, in_valid and out_ready are ignored. Both pointers and count go to 0. Array contents need not be cleared.
- Reset: pointers, count and all outputs are 0. Storage need not be reset because outputs are masked while empty.
- Stall: decode holds out_ready=0. The head packet stays stable on out_* for as many cycles as required.

## Timing
- Write-to-read latency is 1 cycle. A packet pushed at edge N appears on out_* after edge N, with no same-cycle bypass.
- No combinational path exists from in_* to out_*, or from out_ready to in_ready. All outputs decode from registers.
- out_* data comes from a registered read-pointer mux. It changes only after a clock edge at which pop, push-into-empty or flush occurred.
- The flush at edge N makes out_valid=0, count=0 and in_ready=1 visible after edge N. A push in cycle N+1 is accepted normally.
- Asynchronous reset is asserted mid-operation: outputs go to 0 immediately, and the queue is empty on the first clock after deassertion.
- Full throughput: with in_valid=out_ready=1 continuously, one packet passes per cycle and count stays constant.

## Test plan
- Reset with in_valid=1 → out_valid=0, out_instr=0, count=0, in_ready=1 during and after reset.
- Push 0x8C010004/PC+4 0x04/pt=0, then 0x10220003/0x08/pt=1 with out_ready=0 → count=2, head shows 0x8C010004 held across 5 stall cycles, almost_full=0 at count 2 and =1 at count 3 (DEPTH=4).
- Fill to 4 entries, keep in_valid=1 → in_ready=0, fifth packet not accepted. Then raise out_ready for one cycle → entries pop in order, fifth packet accepted the following cycle.
- Streaming 16 sequential packets with in_valid=out_ready=1 → output order matches input with 1-cycle latency, count constant at 1, pointers wrap without loss.
- flush_en with count=3 asserted together with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0, out_* all 0, the pushed packet is discarded.
- Empty queue with push and out_ready=1 in the same cycle → no pop; packet visible next cycle, count=1.
